// File: rtl/memory_cycle_sequencer.sv
// Sequences one external memory/IO bus cycle at a time (setup, strobe, hold)
// for either a CPU bus cycle or an SPI bridge request, with a one-deep CPU pending slot.
module memory_cycle_sequencer #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 3
) (
    input  logic        sys_clock_i,
    input  logic        reset_n_i,
    input  logic        cpu_start_i,
    input  logic        cpu_rw_n_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        ram_en_i,
    input  logic        io_en_i,
    input  logic        is_readonly_i,
    input  logic        decoded_a15_i,
    input  logic        decoded_a16_i,
    input  logic        spi_req_i,
    input  logic        spi_we_i,
    input  logic [16:0] spi_addr_i,
    input  logic [7:0]  spi_data_i,
    output logic        spi_ack_o,
    output logic [7:0]  spi_data_o,
    output logic        cpu_done_o,
    output logic [7:0]  cpu_data_o,
    output logic [16:0] ram_addr_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o,
    output logic        io_oe_n_o,
    output logic        io_we_n_o,
    input  logic [7:0]  mem_data_i,
    output logic [7:0]  mem_data_o,
    output logic        mem_data_oe_o,
    output logic        busy_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    typedef struct packed {
        logic        cpu;
        logic        read;
        logic        ram;
        logic        io;
        logic        ro;
        logic [16:0] addr;
        logic [7:0]  wdata;
    } cycle_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    cycle_t     cur;
    cycle_t     pend;
    logic       pend_valid;
    cycle_t     cpu_in;
    cycle_t     spi_in;
    logic       launch;
    logic       unused_addr_msb;

    // Address bit 15 comes from the decoder, so the raw CPU bit is not used.
    assign unused_addr_msb = cpu_addr_i[15];

    always_comb begin
        cpu_in       = '0;
        cpu_in.cpu   = 1'b1;
        cpu_in.read  = cpu_rw_n_i;
        cpu_in.ram   = ram_en_i;
        cpu_in.io    = io_en_i;
        cpu_in.ro    = is_readonly_i;
        cpu_in.addr  = {decoded_a16_i, decoded_a15_i, cpu_addr_i[14:0]};
        cpu_in.wdata = cpu_data_i;

        spi_in       = '0;
        spi_in.cpu   = 1'b0;
        spi_in.read  = ~spi_we_i;
        spi_in.ram   = 1'b1;
        spi_in.addr  = spi_addr_i;
        spi_in.wdata = spi_data_i;
    end

    assign launch = (state == IDLE) && (cpu_start_i || pend_valid || spi_req_i);

    always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = SETUP;
            SETUP:   if (cnt == SETUP_LAST) state_next = STROBE;
            STROBE:  if (cnt == STROBE_LAST) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt <= '0;
        end else if (state_next != state || state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cur        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            overrun_o  <= 1'b0;
            cpu_data_o <= '0;
            spi_data_o <= '0;
        end else begin
            if (launch) begin
                if (pend_valid) begin
                    cur <= pend;
                end else if (cpu_start_i) begin
                    cur <= cpu_in;
                end else begin
                    cur <= spi_in;
                end
            end

            // A start arriving while the slot drains in IDLE refills it at once.
            if (cpu_start_i) begin
                if (state == IDLE) begin
                    if (pend_valid) pend <= cpu_in;
                end else if (!pend_valid) begin
                    pend       <= cpu_in;
                    pend_valid <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (state == IDLE && pend_valid) begin
                pend_valid <= 1'b0;
            end

            if (state == STROBE && cnt == STROBE_LAST && cur.read) begin
                if (!cur.cpu) begin
                    spi_data_o <= mem_data_i;
                end else if (cur.ram || cur.io) begin
                    cpu_data_o <= mem_data_i;
                end
            end
        end
    end

    always_comb begin
        ram_oe_n_o    = 1'b1;
        ram_we_n_o    = 1'b1;
        io_oe_n_o     = 1'b1;
        io_we_n_o     = 1'b1;
        busy_o        = (state != IDLE);
        mem_data_oe_o = (state != IDLE) && !cur.read;
        cpu_done_o    = (state == HOLD) && cur.cpu;
        spi_ack_o     = (state == HOLD) && !cur.cpu;
        ram_addr_o    = cur.addr;
        mem_data_o    = cur.wdata;
        if (state == STROBE) begin
            ram_oe_n_o = !(cur.ram && cur.read);
            ram_we_n_o = !(cur.ram && !cur.read && !cur.ro);
            io_oe_n_o  = !(cur.io && cur.read);
            io_we_n_o  = !(cur.io && !cur.read);
        end
    end

endmodule

// File: tb/tb_memory_cycle_sequencer.sv
// Bench for memory_cycle_sequencer: directed vector table, random transactions
// against a cycle-timing model, and hand-written tie/overrun/reset sequences.
module tb_memory_cycle_sequencer;

    localparam int S      = 1;
    localparam int T      = 3;
    localparam int HOLD_K = S + T + 1;

    logic        clk;
    logic        rst_n;
    logic        cpu_start;
    logic        cpu_rw_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ram_en;
    logic        io_en;
    logic        is_ro;
    logic        a15;
    logic        a16;
    logic        spi_req;
    logic        spi_we;
    logic [16:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic        spi_ack;
    logic [7:0]  spi_rdata;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;
    logic [16:0] ram_addr;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        io_oe_n;
    logic        io_we_n;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_oe;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;
    logic [7:0] last_cpu = 8'h00;
    logic [7:0] last_spi = 8'h00;

    typedef struct {
        logic        is_spi;
        logic        rd;
        logic [15:0] cpu_addr;
        logic        a15;
        logic        a16;
        logic        ram_en;
        logic        io_en;
        logic        ro;
        logic [16:0] spi_addr;
        logic [7:0]  wdata;
        logic [7:0]  mdata;
        logic [16:0] exp_addr;
        logic [3:0]  exp_mask;   // {ram_oe, ram_we, io_oe, io_we} low during strobe
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t tbl [8];

    memory_cycle_sequencer #(.SETUP_CYCLES(S), .STROBE_CYCLES(T)) dut (
        .sys_clock_i   (clk),
        .reset_n_i     (rst_n),
        .cpu_start_i   (cpu_start),
        .cpu_rw_n_i    (cpu_rw_n),
        .cpu_addr_i    (cpu_addr),
        .cpu_data_i    (cpu_wdata),
        .ram_en_i      (ram_en),
        .io_en_i       (io_en),
        .is_readonly_i (is_ro),
        .decoded_a15_i (a15),
        .decoded_a16_i (a16),
        .spi_req_i     (spi_req),
        .spi_we_i      (spi_we),
        .spi_addr_i    (spi_addr),
        .spi_data_i    (spi_wdata),
        .spi_ack_o     (spi_ack),
        .spi_data_o    (spi_rdata),
        .cpu_done_o    (cpu_done),
        .cpu_data_o    (cpu_rdata),
        .ram_addr_o    (ram_addr),
        .ram_oe_n_o    (ram_oe_n),
        .ram_we_n_o    (ram_we_n),
        .io_oe_n_o     (io_oe_n),
        .io_we_n_o     (io_we_n),
        .mem_data_i    (mem_rdata),
        .mem_data_o    (mem_wdata),
        .mem_data_oe_o (mem_oe),
        .busy_o        (busy),
        .overrun_o     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected {busy, ram_oe_n, ram_we_n, io_oe_n, io_we_n, oe, done, ack, overrun}
    // k cycles after the start was sampled.
    function automatic logic [8:0] exp_ctrl(input vec_t v, input int k);
        logic b;
        logic s;
        logic h;
        b = (k >= 1) && (k <= HOLD_K);
        s = (k >= S + 1) && (k <= S + T);
        h = (k == HOLD_K);
        return {b, ~(s & v.exp_mask[3]), ~(s & v.exp_mask[2]), ~(s & v.exp_mask[1]),
                ~(s & v.exp_mask[0]), b & ~v.rd, h & ~v.is_spi, h & v.is_spi, 1'b0};
    endfunction

    function automatic vec_t make_random();
        vec_t v;
        v.is_spi   = 1'($urandom_range(0, 1));
        v.rd       = 1'($urandom_range(0, 1));
        v.cpu_addr = 16'($urandom_range(0, 16'hFFFF));
        v.a15      = 1'($urandom_range(0, 1));
        v.a16      = 1'($urandom_range(0, 1));
        v.ram_en   = 1'($urandom_range(0, 1));
        v.io_en    = v.ram_en ? 1'b0 : 1'($urandom_range(0, 1));
        v.ro       = 1'($urandom_range(0, 1));
        v.spi_addr = 17'($urandom_range(0, 17'h1FFFF));
        v.wdata    = 8'($urandom_range(0, 255));
        v.mdata    = 8'($urandom_range(0, 255));
        if (v.is_spi) begin
            v.exp_addr  = v.spi_addr;
            v.exp_mask  = v.rd ? 4'b1000 : 4'b0100;
            v.exp_rdata = v.rd ? v.mdata : last_spi;
        end else begin
            v.exp_addr  = 17'(int'(v.a16) * 65536 + int'(v.a15) * 32768 + int'(v.cpu_addr) % 32768);
            v.exp_mask  = {v.ram_en & v.rd, v.ram_en & ~v.rd & ~v.ro, v.io_en & v.rd, v.io_en & ~v.rd};
            v.exp_rdata = (v.rd && (v.ram_en || v.io_en)) ? v.mdata : last_cpu;
        end
        return v;
    endfunction

    task automatic scramble_inputs();
        cpu_rw_n  = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 16'hFFFF));
        cpu_wdata = 8'($urandom_range(0, 255));
        ram_en    = 1'($urandom_range(0, 1));
        io_en     = 1'($urandom_range(0, 1));
        is_ro     = 1'($urandom_range(0, 1));
        a15       = 1'($urandom_range(0, 1));
        a16       = 1'($urandom_range(0, 1));
        spi_we    = 1'($urandom_range(0, 1));
        spi_addr  = 17'($urandom_range(0, 17'h1FFFF));
        spi_wdata = 8'($urandom_range(0, 255));
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        @(negedge clk);
        if (v.is_spi) begin
            spi_req   = 1'b1;
            spi_we    = ~v.rd;
            spi_addr  = v.spi_addr;
            spi_wdata = v.wdata;
        end else begin
            cpu_start = 1'b1;
            cpu_rw_n  = v.rd;
            cpu_addr  = v.cpu_addr;
            cpu_wdata = v.wdata;
            ram_en    = v.ram_en;
            io_en     = v.io_en;
            is_ro     = v.ro;
            a15       = v.a15;
            a16       = v.a16;
        end
        mem_rdata = ~v.mdata;
        @(posedge clk);
        #1;
        cpu_start = 1'b0;
        spi_req   = 1'b0;
        scramble_inputs();
        for (int k = 1; k <= HOLD_K + 1; k++) begin
            @(negedge clk);
            check($sformatf("%s k=%0d ctrl", tag, k),
                  {23'd0, busy, ram_oe_n, ram_we_n, io_oe_n, io_we_n, mem_oe, cpu_done, spi_ack, overrun},
                  {23'd0, exp_ctrl(v, k)});
            if (k == 1) begin
                check($sformatf("%s addr", tag), {15'd0, ram_addr}, {15'd0, v.exp_addr});
                if (!v.rd) check($sformatf("%s wdata", tag), {24'd0, mem_wdata}, {24'd0, v.wdata});
            end
            if (k == HOLD_K) begin
                check($sformatf("%s rdata", tag), {24'd0, v.is_spi ? spi_rdata : cpu_rdata},
                      {24'd0, v.exp_rdata});
            end
            mem_rdata = (k == S + T) ? v.mdata : ~v.mdata;
        end
        if (v.is_spi) last_spi = v.exp_rdata;
        else last_cpu = v.exp_rdata;
    endtask

    initial begin
        int done_k;
        int ack1;
        int ack2;
        int done_cnt;
        int second_done;

        // is_spi, rd, cpu_addr, a15, a16, ram_en, io_en, ro, spi_addr, wdata, mdata, exp_addr, mask, rdata
        tbl[0] = '{1'b0, 1'b1, 16'h9234, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0, 8'h00, 8'h5A, 17'h11234, 4'b1000, 8'h5A};
        tbl[1] = '{1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'h0, 8'hC3, 8'h00, 17'h01000, 4'b0000, 8'h5A};
        tbl[2] = '{1'b0, 1'b0, 16'hE812, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 17'h0, 8'h77, 8'h00, 17'h0E812, 4'b0001, 8'h5A};
        tbl[3] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h1ABCD, 8'h00, 8'h3C, 17'h1ABCD, 4'b1000, 8'h3C};
        tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00042, 8'h99, 8'h00, 17'h00042, 4'b0100, 8'h3C};
        tbl[5] = '{1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00, 8'hEE, 17'h00055, 4'b0000, 8'h5A};
        tbl[6] = '{1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0, 8'h01, 8'h00, 17'h1FFFF, 4'b0100, 8'h5A};
        tbl[7] = '{1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 17'h0, 8'h00, 8'hA5, 17'h08001, 4'b0010, 8'hA5};

        rst_n     = 1'b0;
        cpu_start = 1'b0;
        spi_req   = 1'b0;
        mem_rdata = 8'h00;
        scramble_inputs();
        repeat (2) @(negedge clk);
        check("reset ctrl",
              {23'd0, busy, ram_oe_n, ram_we_n, io_oe_n, io_we_n, mem_oe, cpu_done, spi_ack, overrun},
              {23'd0, 9'b0_1111_0000});
        check("reset addr", {15'd0, ram_addr}, 32'd0);
        check("reset data", {8'd0, cpu_rdata, spi_rdata, mem_wdata}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(make_random(), $sformatf("rnd%0d", i));
        end

        // CPU and SPI request in the same cycle; SPI held high for two cycles.
        @(negedge clk);
        cpu_start = 1'b1; cpu_rw_n = 1'b1; cpu_addr = 16'h0123; ram_en = 1'b1; io_en = 1'b0;
        is_ro = 1'b0; a15 = 1'b0; a16 = 1'b0;
        spi_req = 1'b1; spi_we = 1'b0; spi_addr = 17'h10000;
        mem_rdata = 8'h66;
        @(posedge clk);
        #1 cpu_start = 1'b0;
        done_k = -1; ack1 = -1; ack2 = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) check("tie cpu addr", {15'd0, ram_addr}, 32'h00123);
            if (k == 7) check("tie spi addr", {15'd0, ram_addr}, 32'h10000);
            if (cpu_done && done_k < 0) done_k = k;
            if (spi_ack) begin
                if (ack1 < 0) begin
                    ack1 = k;
                end else if (ack2 < 0) begin
                    ack2 = k;
                    spi_req = 1'b0;
                end
            end
        end
        spi_req = 1'b0;
        check("tie done cycle", done_k, 5);
        check("tie ack cycle", ack1, 11);
        check("tie second ack cycle", ack2, 17);
        check("tie cpu rdata", {24'd0, cpu_rdata}, 32'h66);
        check("tie spi rdata", {24'd0, spi_rdata}, 32'h66);
        check("tie idle after", {31'd0, busy}, 32'd0);

        // Two extra CPU starts during one busy cycle.
        @(negedge clk);
        cpu_start = 1'b1; cpu_rw_n = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 8'hAA;
        ram_en = 1'b1; io_en = 1'b0; is_ro = 1'b0; a15 = 1'b0; a16 = 1'b0;
        @(posedge clk);
        #1 cpu_start = 1'b0;
        done_cnt = 0; second_done = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (cpu_done) begin
                done_cnt++;
                if (done_cnt == 2) second_done = k;
            end
            if (k == 3) check("ovr before second", {31'd0, overrun}, 32'd0);
            if (k == 5) check("ovr after second", {31'd0, overrun}, 32'd1);
            if (k == 7) check("ovr pending addr", {15'd0, ram_addr}, 32'h00200);
            if (k == 8) check("ovr pending strobe", {31'd0, ram_we_n}, 32'd0);
            cpu_start = 1'b0;
            if (k == 2) begin cpu_start = 1'b1; cpu_addr = 16'h0200; end
            if (k == 4) begin cpu_start = 1'b1; cpu_addr = 16'h0300; end
        end
        check("ovr done count", done_cnt, 2);
        check("ovr second done cycle", second_done, 11);
        check("ovr sticky", {31'd0, overrun}, 32'd1);

        // Reset during the strobe of a write.
        @(negedge clk);
        cpu_start = 1'b1; cpu_rw_n = 1'b0; cpu_addr = 16'h0042; cpu_wdata = 8'h5C;
        ram_en = 1'b1; io_en = 1'b0; is_ro = 1'b0;
        @(posedge clk);
        #1 cpu_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst strobe active", {31'd0, ram_we_n}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst strobe released", {31'd0, ram_we_n}, 32'd1);
        check("rst busy", {30'd0, busy, mem_oe}, 32'd0);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cpu_done || busy) done_cnt++;
        end
        check("rst no done", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
